// File: rtl/dac_interface.sv
`default_nettype none
// ============================================================================
// Module      : dac_interface
// Description : Parallel DAC driver. Buffers upstream samples from the
//               SI_data/SI_rdy/SI_ack handshake in a small FIFO and emits
//               one code per DAC clock period, with underrun detection.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_interface #(
  parameter int DATA_WIDTH    = 8,
  parameter int CLK_DIV_WIDTH = 32,
  parameter int FIFO_AW       = 2,
  parameter int IDLE_CODE     = 128
) (
  input  logic                     clk_i,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [CLK_DIV_WIDTH-1:0] interpolation_factor,
  input  logic [DATA_WIDTH-1:0]    SI_data,
  input  logic                     SI_rdy,
  output logic                     SI_ack,
  output logic [DATA_WIDTH-1:0]    DAC_data,
  output logic                     DAC_clk,
  output logic                     underrun_o,
  output logic [15:0]              underrun_count
);

  localparam int                    c_DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]      c_FULL      = (FIFO_AW+1)'(c_DEPTH);
  localparam logic [FIFO_AW:0]      c_HALF      = (FIFO_AW+1)'(c_DEPTH / 2);
  localparam logic [DATA_WIDTH-1:0] c_IDLE_CODE = DATA_WIDTH'(IDLE_CODE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;

  logic [DATA_WIDTH-1:0]    r_mem [c_DEPTH];
  logic [FIFO_AW-1:0]       r_wr_ptr;
  logic [FIFO_AW-1:0]       r_rd_ptr;
  logic [FIFO_AW:0]         r_count;

  logic [CLK_DIV_WIDTH-1:0] r_div_cnt;
  logic                     r_clk_div;
  logic [DATA_WIDTH-1:0]    r_dac_data;
  logic                     r_underrun;
  logic [15:0]              r_underrun_cnt;

  logic w_factor_zero;
  logic w_term;
  logic w_strobe;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_run_strobe;
  logic w_pop;
  logic w_underrun;

  // Terminal count uses >= so a factor lowered mid-run cannot strand the
  // counter above the new limit.
  assign w_factor_zero = (interpolation_factor == '0);
  assign w_term        = w_factor_zero ||
                         (r_div_cnt >= (interpolation_factor - CLK_DIV_WIDTH'(1)));
  // Update on the falling half of the divided clock so the code is settled
  // before the DAC latches on the following rising edge.
  assign w_strobe      = w_factor_zero ? 1'b1 : (w_term && r_clk_div);

  assign w_full        = (r_count == c_FULL);
  assign w_empty       = (r_count == '0);

  assign SI_ack        = SI_rdy && !w_full && enable && !rst;
  assign w_push        = SI_rdy && SI_ack;

  assign w_run_strobe  = (r_state == ST_RUN) && enable && w_strobe;
  assign w_pop         = w_run_strobe && !w_empty;
  assign w_underrun    = w_run_strobe && w_empty;

  assign DAC_clk        = w_factor_zero ? clk_i : r_clk_div;
  assign DAC_data       = r_dac_data;
  assign underrun_o     = r_underrun;
  assign underrun_count = r_underrun_cnt;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; dropping enable returns to IDLE from anywhere
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (enable) w_state_nxt = ST_FILL;
      ST_FILL: if (r_count >= c_HALF) w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!enable) w_state_nxt = ST_IDLE;
  end

  // Clock divider, held cleared while idle or disabled
  always_ff @(posedge clk_i) begin
    if (rst || !enable || (r_state == ST_IDLE) || w_factor_zero) begin
      r_div_cnt <= '0;
      r_clk_div <= 1'b0;
    end else if (w_term) begin
      r_div_cnt <= '0;
      r_clk_div <= ~r_clk_div;
    end else begin
      r_div_cnt <= r_div_cnt + CLK_DIV_WIDTH'(1);
    end
  end

  // FIFO storage write port
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= SI_data;
  end

  // FIFO pointers and occupancy; disabling flushes the contents
  always_ff @(posedge clk_i) begin
    if (rst || !enable) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // DAC output register: mid-scale while idle, FIFO head on each pop
  always_ff @(posedge clk_i) begin
    if (rst || !enable || (r_state == ST_IDLE)) r_dac_data <= c_IDLE_CODE;
    else if (w_pop)                             r_dac_data <= r_mem[r_rd_ptr];
  end

  // Underrun pulse and saturating counter, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst) begin
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_underrun <= w_underrun;
      if (w_underrun && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dac_interface.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dac_interface
// Description : Directed self-checking bench for dac_interface.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_interface;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] interpolation_factor;
  logic [7:0]  SI_data;
  logic        SI_rdy;
  logic        SI_ack;
  logic [7:0]  DAC_data;
  logic        DAC_clk;
  logic        underrun_o;
  logic [15:0] underrun_count;

  int          n_checks = 0;
  int          n_errors = 0;

  // producer control
  int          n_xfer     = 0;
  int          prod_base  = 0;
  int          prod_limit = 1000;
  logic        prod_on    = 1'b1;
  logic [7:0]  prod_start = 8'd1;

  int          k;
  int          bad;
  int          changes;
  int          rises;
  int          highs;
  logic [7:0]  prev_d;
  logic        prev_c;

  dac_interface #(
    .DATA_WIDTH   (8),
    .CLK_DIV_WIDTH(32),
    .FIFO_AW      (2),
    .IDLE_CODE    (128)
  ) dut (
    .clk_i               (clk_i),
    .rst                 (rst),
    .enable              (enable),
    .interpolation_factor(interpolation_factor),
    .SI_data             (SI_data),
    .SI_rdy              (SI_rdy),
    .SI_ack              (SI_ack),
    .DAC_data            (DAC_data),
    .DAC_clk             (DAC_clk),
    .underrun_o          (underrun_o),
    .underrun_count      (underrun_count)
  );

  always #5 clk_i = ~clk_i;

  // count accepted transfers
  always @(posedge clk_i) begin
    if (SI_rdy && SI_ack) n_xfer <= n_xfer + 1;
  end

  // producer: ramp starting at prod_start, up to prod_limit samples
  initial begin
    SI_rdy  = 1'b0;
    SI_data = 8'h00;
    forever begin
      @(negedge clk_i);
      SI_rdy  = prod_on && ((n_xfer - prod_base) < prod_limit);
      SI_data = prod_start + 8'(n_xfer - prod_base);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // disable for two cycles, then restart with a fresh ramp
  task automatic restart(input logic [31:0] f, input logic [7:0] start, input int limit);
    enable  = 1'b0;
    prod_on = 1'b0;
    tick(2);
    interpolation_factor = f;
    prod_base  = n_xfer;
    prod_start = start;
    prod_limit = limit;
    prod_on    = 1'b1;
    enable     = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with enable and producer active
    rst = 1'b1;
    enable = 1'b1;
    interpolation_factor = 32'd3;
    tick(3);
    check_val("t1_dac_data", DAC_data, 8'h80);
    check_val("t1_dac_clk", DAC_clk, 1'b0);
    check_val("t1_si_ack", SI_ack, 1'b0);
    check_val("t1_ucount", underrun_count, 16'd0);
    check_val("t1_upulse", underrun_o, 1'b0);
    rst = 1'b0;

    // 2: factor=2 -> DAC_clk period 4, one new code per period on falling edge
    restart(32'd2, 8'd1, 1000);
    k = 0;
    while (DAC_data === 8'h80 && k < 40) begin tick(1); k++; end
    check_val("t2_first", DAC_data, 8'd1);
    prev_d = DAC_data; prev_c = DAC_clk;
    changes = 0; bad = 0; rises = 0; highs = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (DAC_clk && !prev_c) rises++;
      if (DAC_clk) highs++;
      if (DAC_data !== prev_d) begin
        changes++;
        if (!(prev_c && !DAC_clk) || (DAC_data !== prev_d + 8'd1)) bad++;
      end
      prev_d = DAC_data; prev_c = DAC_clk;
    end
    check_val("t2_bad_steps", bad, 0);
    check_val("t2_changes", changes, 4);
    check_val("t2_rises", rises, 4);
    check_val("t2_high_cycles", highs, 8);
    check_val("t2_last", DAC_data, 8'd5);

    // 3: factor=0 -> DAC_clk mirrors clk_i, one code per cycle
    restart(32'd0, 8'd1, 1000);
    k = 0;
    while (DAC_data === 8'h80 && k < 40) begin tick(1); k++; end
    check_val("t3_first", DAC_data, 8'd1);
    prev_d = DAC_data; bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (DAC_data !== prev_d + 8'd1) bad++;
      prev_d = DAC_data;
    end
    check_val("t3_ramp", bad, 0);
    check_val("t3_clk_high", DAC_clk, 1'b1);
    @(negedge clk_i); #1;
    check_val("t3_clk_low", DAC_clk, 1'b0);
    tick(1);
    check_val("t3_ucount", underrun_count, 16'd0);

    // 4: producer stops after 6 samples, factor=1 -> underruns per strobe
    restart(32'd1, 8'd1, 6);
    k = 0;
    while (DAC_data !== 8'd6 && k < 60) begin tick(1); k++; end
    check_val("t4_last_sample", DAC_data, 8'd6);
    k = 0;
    while (underrun_o !== 1'b1 && k < 10) begin tick(1); k++; end
    check_val("t4_pulse1", underrun_o, 1'b1);
    check_val("t4_count1", underrun_count, 16'd1);
    tick(1);
    check_val("t4_gap", underrun_o, 1'b0);
    check_val("t4_count_gap", underrun_count, 16'd1);
    tick(1);
    check_val("t4_pulse2", underrun_o, 1'b1);
    check_val("t4_count2", underrun_count, 16'd2);
    tick(2);
    check_val("t4_count3", underrun_count, 16'd3);
    check_val("t4_hold", DAC_data, 8'd6);

    // 5: slow consumer (factor=10): fill to depth, then back-pressure
    restart(32'd10, 8'd1, 1000);
    tick(2);
    check_val("t5_two_acks", n_xfer - prod_base, 2);
    tick(6);
    check_val("t5_full_xfers", n_xfer - prod_base, 4);
    check_val("t5_rdy", SI_rdy, 1'b1);
    check_val("t5_no_ack_full", SI_ack, 1'b0);
    check_val("t5_no_pop_yet", DAC_data, 8'h80);
    k = 0;
    while (DAC_data === 8'h80 && k < 40) begin tick(1); k++; end
    check_val("t5_first_pop", DAC_data, 8'd1);
    check_val("t5_ack_after_pop", SI_ack, 1'b1);

    // 6: drop enable mid-RUN with 3 samples buffered
    prod_on = 1'b0;
    k = 0;
    while (DAC_clk !== 1'b1 && k < 30) begin tick(1); k++; end
    check_val("t6_clk_high_before", DAC_clk, 1'b1);
    enable = 1'b0;
    tick(1);
    check_val("t6_idle_code", DAC_data, 8'h80);
    check_val("t6_clk_low", DAC_clk, 1'b0);
    check_val("t6_ucount_kept", underrun_count, 16'd3);
    restart(32'd0, 8'h40, 1000);
    k = 0;
    while (DAC_data === 8'h80 && k < 40) begin tick(1); k++; end
    check_val("t6_flushed_first", DAC_data, 8'h40);
    tick(1);
    check_val("t6_second", DAC_data, 8'h41);

    // reset mid-stream clears everything and blocks SI_ack
    rst = 1'b1;
    tick(2);
    check_val("rst_ucount", underrun_count, 16'd0);
    check_val("rst_dac_data", DAC_data, 8'h80);
    check_val("rst_si_ack", SI_ack, 1'b0);
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
